// File: rtl/adder_pipe_n.sv
// Pipelined N-bit adder/subtractor. One N/STAGES-bit slice is added per stage, and the carry
// ripples from stage to stage. Valid/ready handshake on both sides; bubbles collapse.
module adder_pipe_n #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int W    = N / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] v_reg;
    logic [STAGES-1:0] c_reg;
    logic [N-1:0]      a_reg  [STAGES];
    logic [N-1:0]      bx_reg [STAGES];
    logic [N-1:0]      s_reg  [STAGES];
    logic              ovf_reg;
    logic              zero_reg;

    logic [STAGES-1:0] load_en;
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] c_next;
    logic [N-1:0]      a_src  [STAGES];
    logic [N-1:0]      bx_src [STAGES];
    logic [N-1:0]      s_src  [STAGES];
    logic [N-1:0]      s_next [STAGES];
    logic [W:0]        part   [STAGES];
    logic              ovf_next;
    logic              zero_next;

    // A stage can take new contents unless it and every stage after it are full while
    // the consumer stalls; this is the collapsed form of "empty or advancing".
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_load
            assign load_en[gi] = out_ready | ~(&v_reg[STAGES-1:gi]);
        end
    endgenerate

    assign in_ready = load_en[0];

    always_comb begin
        v_src[0]  = in_valid;
        a_src[0]  = a;
        bx_src[0] = b ^ {N{sub}};
        s_src[0]  = '0;
        c_src[0]  = cin ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k]  = v_reg[k-1];
            a_src[k]  = a_reg[k-1];
            bx_src[k] = bx_reg[k-1];
            s_src[k]  = s_reg[k-1];
            c_src[k]  = c_reg[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_src[k][k*W +: W]} + {1'b0, bx_src[k][k*W +: W]}
                    + {{W{1'b0}}, c_src[k]};
            s_next[k] = s_src[k];
            s_next[k][k*W +: W] = part[k][W-1:0];
            c_next[k] = part[k][W];
        end
        // Flags need the complete sum, so they are formed only as the last slice lands.
        ovf_next  = (a_src[LAST][N-1] == bx_src[LAST][N-1]) &&
                    (s_next[LAST][N-1] != a_src[LAST][N-1]);
        zero_next = ~|s_next[LAST];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg    <= '0;
            c_reg    <= '0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k]  <= '0;
                bx_reg[k] <= '0;
                s_reg[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load_en[k]) begin
                    v_reg[k] <= v_src[k];
                    if (v_src[k]) begin
                        a_reg[k]  <= a_src[k];
                        bx_reg[k] <= bx_src[k];
                        s_reg[k]  <= s_next[k];
                        c_reg[k]  <= c_next[k];
                    end
                end
            end
            if (load_en[LAST] && v_src[LAST]) begin
                ovf_reg  <= ovf_next;
                zero_reg <= zero_next;
            end
        end
    end

    assign out_valid = v_reg[LAST];
    assign sum       = s_reg[LAST];
    assign cout      = c_reg[LAST];
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule
